// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one word load/store at a time, serviced
// after a fixed latency from a big-endian byte store, with misalign/range error.

module data_mem_responder_chk #(
    parameter logic [3:0] LAT_LOAD = 4'd1
) (
    input logic       clk,
    input logic       reset,
    input logic       req_ready,
    input logic       resp_valid,
    input logic [3:0] cnt
);

    // A request is never offered acceptance while a response is pending.
    a_ready_resp_excl: assert property (@(posedge clk) disable iff (reset)
        !(req_ready && resp_valid));

    // The latency counter never exceeds its load value.
    a_cnt_range: assert property (@(posedge clk) disable iff (reset)
        (cnt <= LAT_LOAD));

endmodule

module data_mem_responder #(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 6,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         WA_W     = ADDR_W - 2;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned word or any address bit above the store range set.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> ADDR_W) != 32'd0);
    endfunction

    logic [7:0]       mem_r [DEPTH_BYTES];
    state_t           state_r;
    logic [3:0]       cnt_r;
    logic             wr_r;
    logic             err_r;
    logic [31:0]      wdata_r;
    logic [WA_W-1:0]  waddr_r;
    logic             req_ready_r;
    logic             resp_valid_r;
    logic [31:0]      resp_rdata_r;
    logic             resp_err_r;

    logic             req_fire_s;
    logic             resp_fire_s;
    logic             commit_s;
    logic [31:0]      rd_word_s;
    logic [ADDR_W-1:0] idx0_s;
    logic [ADDR_W-1:0] idx1_s;
    logic [ADDR_W-1:0] idx2_s;
    logic [ADDR_W-1:0] idx3_s;

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    assign req_fire_s  = req_valid && req_ready_r;
    assign resp_fire_s = resp_valid_r && resp_ready;

    // Byte lane indices of the captured word; aligned so lanes never wrap.
    always_comb begin
        idx0_s = {waddr_r, 2'b00};
        idx1_s = {waddr_r, 2'b01};
        idx2_s = {waddr_r, 2'b10};
        idx3_s = {waddr_r, 2'b11};
    end

    // Big-endian word read: lowest address lands in bits 31:24.
    always_comb begin
        rd_word_s = 32'd0;
        rd_word_s = {mem_r[idx0_s], mem_r[idx1_s], mem_r[idx2_s], mem_r[idx3_s]};
    end

    // Store commit happens only on the final wait edge of a clean store.
    always_comb begin
        if ((state_r == ST_WAIT) && (cnt_r == 4'd0) && wr_r && !err_r && !reset) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Byte store; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx0_s] <= wdata_r[31:24];
            mem_r[idx1_s] <= wdata_r[23:16];
            mem_r[idx2_s] <= wdata_r[15:8];
            mem_r[idx3_s] <= wdata_r[7:0];
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            wr_r         <= 1'b0;
            err_r        <= 1'b0;
            wdata_r      <= 32'd0;
            waddr_r      <= '0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        wr_r        <= req_write;
                        err_r       <= addr_err(req_addr);
                        wdata_r     <= req_wdata;
                        waddr_r     <= req_addr[ADDR_W-1:2];
                        cnt_r       <= LAT_LOAD;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= err_r;
                        resp_rdata_r <= (wr_r || err_r) ? 32'd0 : rd_word_s;
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Ready reasserts on the fire edge so the next request
                    // can be taken one edge later.
                    if (resp_fire_s) begin
                        resp_valid_r <= 1'b0;
                        resp_rdata_r <= 32'd0;
                        resp_err_r   <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= 4'd0;
                    req_ready_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    data_mem_responder_chk #(
        .LAT_LOAD (LAT_LOAD)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .req_ready  (req_ready_r),
        .resp_valid (resp_valid_r),
        .cnt        (cnt_r)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table of transactions plus
// hand-written stall, timing and mid-operation reset sequences.

module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    data_mem_responder #(
        .DEPTH_BYTES (64),
        .ADDR_W      (6),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction with resp_ready held high; checks timing.
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata);
        int guard;
        int lat;
        logic busy_ok;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready_before"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble inputs to show they are not sampled after acceptance.
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_AAAA;
        lat = 0;
        busy_ok = 1'b1;
        while (!resp_valid && lat < 20) begin
            if (req_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_ready_low_busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_ready_low_resp"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        req_write = 1'b0;
    endtask

    initial begin
        int guard;
        logic quiet;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_000A, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h0000_003C, 32'hA5A5_5A5A, 1'b0, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'h0000_003C, 32'h0000_0000, 1'b0, 32'hA5A5_5A5A};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0102_0304};
        vecs[9]  = '{1'b0, 32'h0000_0041, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h8000_0008, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 1'b0, 32'h0000_0000};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};
        vecs[13] = '{1'b0, 32'h0000_003D, 32'h0000_0000, 1'b1, 32'h0000_0000};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            xact($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Byte order and no-wrap in the store itself.
        check("mem8", {24'd0, dut.mem_r[8]}, 32'h0000_00DE);
        check("mem11", {24'd0, dut.mem_r[11]}, 32'h0000_00EF);
        check("mem60", {24'd0, dut.mem_r[60]}, 32'h0000_00A5);
        check("mem63", {24'd0, dut.mem_r[63]}, 32'h0000_005A);
        check("mem0", {24'd0, dut.mem_r[0]}, 32'h0000_0001);

        // Back-pressure: response held for 5 cycles, offered store ignored.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h0000_0008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("stall_latency", 32'(guard), 32'(LAT));
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0000;
        req_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", k), {31'd0, resp_valid}, 32'd1);
            check($sformatf("stall%0d_rdata", k), resp_rdata, 32'hDEAD_BEEF);
            check($sformatf("stall%0d_err", k), {31'd0, resp_err}, 32'd0);
            check($sformatf("stall%0d_ready", k), {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        req_write  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", {31'd0, resp_valid}, 32'd0);
        check("stall_release_ready", {31'd0, req_ready}, 32'd1);
        xact("stall_probe", 1'b0, 32'h0000_0000, 32'd0, 1'b0, 32'h0102_0304);

        // Reset one cycle after a store is accepted drops the store.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (resp_valid) quiet = 1'b0;
        end
        check("midrst_no_resp", {31'd0, quiet}, 32'd1);
        check("midrst_ready_after", {31'd0, req_ready}, 32'd1);
        check("midrst_mem16", {24'd0, dut.mem_r[16]}, 32'h0000_000B);
        xact("midrst_probe", 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the processor's data-memory port: it accepts one word load or store request at a time over a valid/ready handshake, services it after a fixed programmable latency from a byte-addressed, big-endian local store, and returns read data plus an error flag over a second valid/ready handshake. It replaces the zero-latency combinational data array when the processor core is moved to a handshaked multi-cycle memory interface.

## Interface
- DEPTH_BYTES, 64, size of byte store; power of two, at least 4
- ADDR_W, 6, log2(DEPTH_BYTES); in-range address bits
- LATENCY, 2, cycles from request accept to response valid; at least 1, at most 15

- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store word, 0 = load word
- req_addr  in  32  byte address
- req_wdata  in  32  store data; bits 31:24 go to the lowest address
- resp_valid  out  1  response present
- resp_ready  in  1  requester takes response
- resp_rdata  out  32  load data (big-endian); 0 for stores and errors
- resp_err  out  1  request was misaligned or out of range

## Operation
- Request fires on a posedge with req_valid && req_ready; req_write, req_addr, req_wdata are captured at that edge and are not sampled afterwards.
- Error check at capture: err = (req_addr[1:0] != 0) || (req_addr[31:ADDR_W] != 0). Errored requests never modify the store.
- Byte order: word at address A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}; stores write the same lanes in the same order. Aligned in-range accesses never wrap.
- FSM states:
  - IDLE: req_ready = 1, resp_valid = 0. On request fire, load the latency counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready = 0. Count down. On the edge where the counter is 0, perform the access (store commits, or load data is latched into resp_rdata), then go to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are held stable. On resp_valid && resp_ready, go to IDLE.
- Only one request is outstanding. No request is accepted during WAIT or RESP, and none is accepted on the same edge as a response fires.
- Store contents are not cleared by reset and are undefined until written. Reset affects only control state and outputs.

## Timing
- Reset values: req_ready = 0 while reset is asserted; req_ready = 1 in the first cycle after reset deasserts (state IDLE); resp_valid = 0; resp_rdata = 0; resp_err = 0; counter = 0.
- Latency: request fires on edge N. The access executes on edge N+LATENCY. resp_valid is high from edge N+LATENCY until the response-fire edge, inclusive of the cycle before that edge.
- With resp_ready held at 1, a new request can be accepted on edge N+LATENCY+2. Minimum request spacing is LATENCY+2 cycles.
- Read-after-write: a load accepted after a store's response fires returns the stored data.
- Reset mid-operation: reset during WAIT drops the request. A pending store is not committed and no response is produced. Reset during RESP discards the response.
- resp_err responses still observe the full LATENCY; error checking does not shortcut the latency.

## Test plan
- Reset, then store 0xDEADBEEF at addr 0x08, then load 0x08 -> store response has err = 0 and rdata = 0; load rdata = 0xDEADBEEF; mem[8] = 0xDE and mem[11] = 0xEF.
- With LATENCY = 2: request fires at edge N -> resp_valid rises after edge N+2. req_ready stays 0 from edge N until the cycle after the response fires.
- resp_ready held 0 for 5 cycles -> resp_valid and rdata stay stable, req_ready stays 0, and a request offered during this time is not accepted.
- Store to 0x0A (misaligned) and store to 0x40 (out of range, DEPTH 64) -> both return err = 1 and rdata = 0. A following load of 0x08 still returns the prior value.
- Store to 0x3C (last word), then load 0x3C -> data returned correctly, with no wrap into 0x00.
- Store 0x11111111 to 0x10, then assert reset one cycle after accept -> no response; after reset, a load of 0x10 returns the value held before the dropped store.
